// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : pre-IF fetch sequencer, one outstanding I-cache request,
//              stall buffering and redirect/cancel handling.
// Rev 1.0
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  input  logic        Stall,
  output logic        IReq_Valid,
  output logic [31:0] IReq_Addr,
  input  logic        IReq_Ready,
  input  logic        IResp_Valid,
  input  logic [31:0] IResp_Data,
  output logic [31:0] PREIF_PC,
  output logic        PREIF_AdEL,
  output logic [31:0] IF_Instr,
  output logic        IF_Wr,
  output logic        IF_Flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] buf_r;
  logic [31:0] pc_inc;
  logic        misaligned;

  assign pc_inc     = pc_r + 32'd4;
  assign misaligned = (pc_r[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc_r  <= RESET_PC;
      buf_r <= 32'd0;
    end else if (Redirect_Valid) begin
      pc_r <= Redirect_PC;
      // An in-flight fetch that has not returned yet must be drained first
      if ((state == S_WAIT || state == S_DROP) && !IResp_Valid)
        state <= S_DROP;
      else
        state <= S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (misaligned) begin
            if (!Stall) pc_r <= pc_inc;
          end else if (IReq_Ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (IResp_Valid) begin
            if (!Stall) begin
              pc_r  <= pc_inc;
              state <= S_REQ;
            end else begin
              buf_r <= IResp_Data;
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            pc_r  <= pc_inc;
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (IResp_Valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign PREIF_PC  = rst ? RESET_PC : pc_r;
  assign IReq_Addr = rst ? RESET_PC : pc_r;

  always_comb begin
    IReq_Valid = 1'b0;
    IF_Wr      = 1'b0;
    IF_Instr   = 32'd0;
    PREIF_AdEL = 1'b0;
    IF_Flush   = 1'b0;
    if (!rst) begin
      IF_Flush = Redirect_Valid;
      case (state)
        S_REQ: begin
          if (misaligned) begin
            PREIF_AdEL = 1'b1;
            IF_Wr      = !Stall && !Redirect_Valid;
          end else begin
            IReq_Valid = !Redirect_Valid;
          end
        end
        S_WAIT: begin
          if (IResp_Valid) begin
            IF_Instr = IResp_Data;
            IF_Wr    = !Stall && !Redirect_Valid;
          end
        end
        S_HOLD: begin
          IF_Instr = buf_r;
          IF_Wr    = !Stall && !Redirect_Valid;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the pre-IF/IF boundary of the pipeline. It owns the fetch PC and issues one instruction-cache request at a time over a valid/ready handshake. It drives PREIF_PC, the AdEL flag, IF_Wr and IF_Flush into the IF pipeline register. It handles downstream stalls by buffering the returned instruction, and handles redirects from branch and exception logic, including cancelling an in-flight fetch.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch PC after reset.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
Redirect_Valid  in  1  redirect request (branch/exception, priority resolved upstream)
Redirect_PC  in  32  redirect target
Stall  in  1  IF register must not be written this cycle
IReq_Valid  out  1  I-cache request valid
IReq_Addr  out  32  I-cache request address
IReq_Ready  in  1  I-cache accepts request
IResp_Valid  in  1  I-cache response valid (one cycle per accepted request)
IResp_Data  in  32  returned instruction
PREIF_PC  out  32  PC of fetch being delivered (to IF register)
PREIF_AdEL  out  1  fetch-address-misaligned exception flag (to IF register)
IF_Instr  out  32  delivered instruction
IF_Wr  out  1  IF register write enable
IF_Flush  out  1  IF register flush

Behaviour:
- State register holds state, pc_r, buf_r (instruction buffer). All are asynchronously reset by rst.
- Reset values: state=S_REQ, pc_r=RESET_PC, buf_r=0.
- While rst=1, outputs are forced to: IReq_Valid=0, IF_Wr=0, IF_Flush=0, PREIF_AdEL=0, IF_Instr=0, PREIF_PC=IReq_Addr=RESET_PC.
- Combinational output mapping:
  - PREIF_PC = IReq_Addr = pc_r.
  - PREIF_AdEL = (pc_r[1:0]!=0) in S_REQ, else 0.
- Maximum one outstanding cache request.
- States: S_REQ, S_WAIT, S_HOLD, S_DROP.
- S_REQ, aligned pc_r:
  - IReq_Valid = !Redirect_Valid.
  - On IReq_Valid & IReq_Ready -> S_WAIT.
  - pc_r is stable while valid is pending.
  - Deasserting valid on a redirect before acceptance is legal for our cache.
- S_REQ, misaligned pc_r:
  - No request is issued.
  - If !Stall & !Redirect_Valid: IF_Wr=1, PREIF_AdEL=1, IF_Instr=0, pc_r <= pc_r+4, stay in S_REQ.
- S_WAIT, on IResp_Valid:
  - If !Stall: IF_Wr=1, IF_Instr=IResp_Data (same cycle, zero added latency), pc_r <= pc_r+4, -> S_REQ.
  - If Stall: buf_r <= IResp_Data, -> S_HOLD.
- S_HOLD:
  - IF_Instr = buf_r.
  - When !Stall: IF_Wr=1, pc_r <= pc_r+4, -> S_REQ.
- S_DROP: the in-flight response is discarded on IResp_Valid (no IF_Wr), -> S_REQ.
- Redirect_Valid (highest priority, any state):
  - IF_Flush=1 in the same cycle (combinational); IF_Wr forced 0.
  - pc_r <= Redirect_PC.
  - S_REQ/S_HOLD -> S_REQ; buf_r contents are dropped.
  - S_WAIT with IResp_Valid in the same cycle -> response discarded, -> S_REQ.
  - S_WAIT without IResp_Valid -> S_DROP.
  - S_DROP without IResp_Valid -> stays S_DROP with the new pc_r.
  - S_DROP with IResp_Valid -> S_REQ.
- IF_Flush=0 whenever Redirect_Valid=0.
- Stall never blocks request issue; it only blocks IF_Wr.
- Arithmetic: pc_r+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset mid-operation: returns to reset values immediately. The cache is reset jointly, so no stale response is expected.

Test Plan:
- Reset release, IReq_Ready=1, 1-cycle response, Stall=0 -> IReq_Addr sequence BFC0_0000, BFC0_0004, BFC0_0008; IF_Wr pulses in each response cycle with matching PREIF_PC/IF_Instr.
- Response for 0xBFC0_0004 (data 0x2402_0001) arrives with Stall=1 for 3 cycles -> IF_Wr=0 for 3 cycles, then IF_Wr=1 with IF_Instr=0x2402_0001, PREIF_PC=0xBFC0_0004; next request is 0xBFC0_0008.
- Redirect to 0x8000_0180 while in S_WAIT, response 2 cycles later -> IF_Flush=1 in the redirect cycle, no IF_Wr for the discarded response, next IReq_Addr=0x8000_0180.
- Redirect in the same cycle as IResp_Valid -> response dropped, IF_Flush=1, IF_Wr=0, immediately in S_REQ at the target.
- Redirect to 0x8000_0002 -> no IReq_Valid; IF_Wr=1, PREIF_AdEL=1, PREIF_PC=0x8000_0002; a second redirect to 0xBFC0_0380 resumes normal fetch.
- Assert rst asynchronously mid-S_WAIT -> outputs go to reset values before the next clk edge; after release, fetch restarts at 0xBFC0_0000.
